// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default width for the bit-serial adder
package serial_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle between a requester and the serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/fa_bit.sv
// fa_bit: single combinational full-adder cell
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell over WIDTH bit pairs, LSB first
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic             clk,
    input logic             reset,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr, b_sr, acc, sum_r;
    logic             c, cmsb, cout_r, ovf_r;
    logic             s, co, accept, step, last;
    assign last = count == CW'(WIDTH - 1);
    fa_bit u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(c), .s(s), .cout(co));
    // state register
    always_ff @(posedge clk) state <= reset ? ST_IDLE : state_nx;
    // next state and status decode; unused encoding falls back to IDLE
    always_comb begin
        state_nx = ST_IDLE;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                accept   = bus.start;
                state_nx = bus.start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                step     = 1'b1;
                state_nx = last ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end
    // operand capture, bit-serial shift, and result latch on the final bit
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            sum_r  <= '0;
            c      <= 1'b0;
            cmsb   <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            c     <= bus.cin;
            count <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            c     <= co;
            acc   <= {s, acc[WIDTH-1:1]};
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 2)) cmsb <= co;
            if (last) begin
                sum_r  <= {s, acc[WIDTH-1:1]};
                cout_r <= co;
                ovf_r  <= cmsb ^ co;
            end
        end
    end
    assign bus.busy = (state == ST_RUN) || (state == ST_DONE);
    assign bus.done = state == ST_DONE;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule
